// File: rtl/pixel_stream_tx_pkg.sv
// Shared project constants for the MNIST front end.
// Image geometry plus a small width helper used for index ports.
package pixel_stream_tx_pkg;

   localparam int MNIST_WIDTH  = 28;
   localparam int MNIST_HEIGHT = 28;

   // Index width that never collapses to zero bits.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_stream_tx.sv
// Frame buffer that serialises a stored binary image in raster order,
// followed by a zero-pixel drain tail.
module pixel_stream_tx
   import pixel_stream_tx_pkg::*;
#(
   parameter int WIDTH  = MNIST_WIDTH,
   parameter int HEIGHT = MNIST_HEIGHT,
   parameter int TAIL   = 64,
   localparam int RW    = idx_bits(HEIGHT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [RW-1:0]    wr_row,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_err,
   input  logic             start,
   output logic             pixel_out,
   output logic             pixel_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy
);

   localparam int CW = idx_bits(WIDTH);
   localparam int TW = idx_bits(TAIL);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_TAIL   = 2'd2;

   localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
   localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL - 1);

   logic [1:0]       state;
   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic [TW-1:0]    tcnt;
   logic [WIDTH-1:0] img [HEIGHT];

   logic          last;
   logic [CW-1:0] ncol;
   logic [RW-1:0] nrow;
   logic          wr_ok;
   logic          wr_bad;

   // col/row always name the pixel currently on pixel_out.
   always_comb begin
      last   = (row == ROW_LAST) && (col == COL_LAST);
      ncol   = (col == COL_LAST) ? '0 : col + CW'(1);
      nrow   = (col == COL_LAST) ? row + RW'(1) : row;
      wr_ok  = wr_en && (state == S_IDLE) && !start
               && (wr_row <= ROW_LAST);
      wr_bad = wr_en && !wr_ok;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         col         <= '0;
         row         <= '0;
         tcnt        <= '0;
         pixel_out   <= 1'b0;
         pixel_valid <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         busy        <= 1'b0;
         wr_err      <= 1'b0;
         for (int r = 0; r < HEIGHT; r++) img[r] <= '0;
      end else begin
         wr_err      <= wr_bad;
         frame_start <= 1'b0;
         if (wr_ok) img[wr_row] <= wr_data;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_STREAM;
                  busy        <= 1'b1;
                  col         <= '0;
                  row         <= '0;
                  pixel_out   <= img[0][0];
                  pixel_valid <= 1'b1;
                  frame_start <= 1'b1;
                  frame_end   <= (ROW_LAST == '0) && (COL_LAST == '0);
               end
            end
            S_STREAM: begin
               if (last) begin
                  pixel_out   <= 1'b0;
                  pixel_valid <= 1'b0;
                  frame_end   <= 1'b0;
                  col         <= '0;
                  row         <= '0;
                  tcnt        <= '0;
                  if (TAIL > 0) begin
                     state <= S_TAIL;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  col       <= ncol;
                  row       <= nrow;
                  pixel_out <= img[nrow][ncol];
                  frame_end <= (nrow == ROW_LAST) && (ncol == COL_LAST);
               end
            end
            S_TAIL: begin
               if (tcnt == TAIL_LAST) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            default: begin
               state       <= S_IDLE;
               busy        <= 1'b0;
               pixel_out   <= 1'b0;
               pixel_valid <= 1'b0;
               frame_end   <= 1'b0;
            end
         endcase
      end
   end

endmodule
